// File: rtl/pwm_capture_pkg.sv
// Shared constants for the PWM capture block: default counter width and FSM state encoding.
package pwm_capture_pkg;

   localparam int unsigned COUNTER_WIDTH_DEFAULT = 16;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_HIGH = 2'd1;
   localparam logic [1:0] ST_LOW  = 2'd2;

endpackage

// File: rtl/pwm_edge_sync.sv
// Two-flop synchronizer on the PWM line plus a ce-gated previous-level register.
// Emits rise/fall strobes only on ce ticks.
module pwm_edge_sync (
   input  logic clk,
   input  logic rst,
   input  logic ce,
   input  logic pwm,
   output logic rise,
   output logic fall
);

   logic sync1_q;
   logic sync2_q;
   logic prev_q;

   // Reset to 1 so a line already high at reset does not look like a rising edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         prev_q  <= 1'b1;
      end else begin
         sync1_q <= pwm;
         sync2_q <= sync1_q;
         if (ce) begin
            prev_q <= sync2_q;
         end
      end
   end

   assign rise = ce & sync2_q & ~prev_q;
   assign fall = ce & ~sync2_q & prev_q;

endmodule

// File: rtl/pwm_capture.sv
// PWM period/high-time capture: counts ce ticks between edges and publishes
// one {period, duty} pair on every rising edge after lock.
module pwm_capture
   import pwm_capture_pkg::*;
#(
   parameter int unsigned counter_width = COUNTER_WIDTH_DEFAULT
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_ce,
   input  logic                     i_pwm,
   output logic [counter_width-1:0] o_period,
   output logic [counter_width-1:0] o_duty,
   output logic                     o_valid,
   output logic                     o_overflow,
   output logic                     o_locked
);

   localparam logic [counter_width-1:0] CntOne = counter_width'(1);
   localparam logic [counter_width-1:0] CntMax = '1;

   logic                     rise;
   logic                     fall;
   logic [1:0]               state_q, state_d;
   logic [counter_width-1:0] cnt_period_q, cnt_period_d;
   logic [counter_width-1:0] cnt_high_q, cnt_high_d;
   logic [counter_width-1:0] period_q, period_d;
   logic [counter_width-1:0] duty_q, duty_d;
   logic                     valid_q, valid_d;
   logic                     overflow_q, overflow_d;

   pwm_edge_sync u_edge_sync (
      .clk  (i_clk),
      .rst  (i_rst),
      .ce   (i_ce),
      .pwm  (i_pwm),
      .rise (rise),
      .fall (fall)
   );

   always_comb begin
      state_d      = state_q;
      cnt_period_d = cnt_period_q;
      cnt_high_d   = cnt_high_q;
      period_d     = period_q;
      duty_d       = duty_q;
      valid_d      = 1'b0;
      overflow_d   = 1'b0;
      if (i_ce) begin
         case (state_q)
            ST_IDLE: begin
               if (rise) begin
                  cnt_period_d = CntOne;
                  cnt_high_d   = CntOne;
                  state_d      = ST_HIGH;
               end
            end
            ST_HIGH: begin
               // Overflow preempts the wrap; a rise cannot occur while high.
               if (cnt_period_q == CntMax) begin
                  overflow_d = 1'b1;
                  state_d    = ST_IDLE;
               end else if (fall) begin
                  cnt_period_d = cnt_period_q + CntOne;
                  state_d      = ST_LOW;
               end else begin
                  cnt_period_d = cnt_period_q + CntOne;
                  cnt_high_d   = cnt_high_q + CntOne;
               end
            end
            ST_LOW: begin
               // Rise wins over overflow, so a full all-ones period is still captured.
               if (rise) begin
                  period_d     = cnt_period_q;
                  duty_d       = cnt_high_q;
                  valid_d      = 1'b1;
                  cnt_period_d = CntOne;
                  cnt_high_d   = CntOne;
                  state_d      = ST_HIGH;
               end else if (cnt_period_q == CntMax) begin
                  overflow_d = 1'b1;
                  state_d    = ST_IDLE;
               end else begin
                  cnt_period_d = cnt_period_q + CntOne;
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q      <= ST_IDLE;
         cnt_period_q <= '0;
         cnt_high_q   <= '0;
         period_q     <= '0;
         duty_q       <= '0;
         valid_q      <= 1'b0;
         overflow_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_period_q <= cnt_period_d;
         cnt_high_q   <= cnt_high_d;
         period_q     <= period_d;
         duty_q       <= duty_d;
         valid_q      <= valid_d;
         overflow_q   <= overflow_d;
      end
   end

   assign o_period   = period_q;
   assign o_duty     = duty_q;
   assign o_valid    = valid_q;
   assign o_overflow = overflow_q;
   assign o_locked   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture: directed and random PWM stimulus checked every cycle
// against a tick-level model of rising/falling edge times.
module tb_pwm_capture;

   localparam int unsigned W = 8;
   localparam int MaxCnt = (1 << W) - 1;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         ce  = 1'b0;
   logic         pwm = 1'b1;
   logic [W-1:0] period;
   logic [W-1:0] duty;
   logic         valid;
   logic         overflow;
   logic         locked;

   int n_checks = 0;
   int n_fail   = 0;
   int vcount   = 0;
   int ocount   = 0;
   int cyc      = 0;

   // Model: pin history (two edges deep), last sampled level and edge tick times.
   bit mp1 = 1'b1, mp2 = 1'b1, mr1 = 1'b1, mr2 = 1'b1;
   bit mprev = 1'b1;
   bit mlocked = 1'b0;
   int t = 0;
   int last_rise = 0;
   int fall_tick = 0;
   int e_period = 0;
   int e_duty = 0;
   bit e_valid = 1'b0;
   bit e_ovf = 1'b0;

   always #5 clk = ~clk;

   pwm_capture #(.counter_width(W)) dut (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_ce       (ce),
      .i_pwm      (pwm),
      .o_period   (period),
      .o_duty     (duty),
      .o_valid    (valid),
      .o_overflow (overflow),
      .o_locked   (locked)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %0d, expected %0d", tag, cyc, obs, exp);
      end
   endtask

   // Level seen on a ce tick is the pin two edges earlier, or 1 if the
   // synchronizer was held in reset during that window.
   task automatic model_edge();
      bit lvl, r, f;
      e_valid = 1'b0;
      e_ovf   = 1'b0;
      if (rst) begin
         e_period = 0;
         e_duty   = 0;
         mlocked  = 1'b0;
         mprev    = 1'b1;
      end else if (ce) begin
         lvl   = (mr1 || mr2) ? 1'b1 : mp2;
         r     = lvl && !mprev;
         f     = !lvl && mprev;
         mprev = lvl;
         if (mlocked) begin
            if (r) begin
               e_period  = t - last_rise;
               e_duty    = fall_tick - last_rise;
               e_valid   = 1'b1;
               last_rise = t;
            end else if (t - last_rise >= MaxCnt) begin
               e_ovf   = 1'b1;
               mlocked = 1'b0;
            end else if (f) begin
               fall_tick = t;
            end
         end else if (r) begin
            mlocked   = 1'b1;
            last_rise = t;
         end
         t++;
      end
      mp2 = mp1;
      mp1 = pwm;
      mr2 = mr1;
      mr1 = rst;
   endtask

   task automatic cycle();
      @(posedge clk);
      model_edge();
      cyc++;
      #1;
      check_eq("valid", 32'(valid), 32'(e_valid));
      check_eq("overflow", 32'(overflow), 32'(e_ovf));
      check_eq("locked", 32'(locked), 32'(mlocked));
      check_eq("period", 32'(period), 32'(e_period));
      check_eq("duty", 32'(duty), 32'(e_duty));
      if (valid) vcount++;
      if (overflow) ocount++;
   endtask

   task automatic drive(input bit level, input int n);
      for (int i = 0; i < n; i++) begin
         pwm = level;
         ce  = 1'b1;
         cycle();
      end
   endtask

   task automatic run_pwm(input int p, input int d, input int div, input int nper);
      for (int k = 0; k < nper; k++) begin
         for (int i = 0; i < p * div; i++) begin
            pwm = (i < d * div);
            ce  = (cyc % div == 0);
            cycle();
         end
      end
   endtask

   task automatic flush(input int div);
      for (int i = 0; i < 4; i++) begin
         pwm = 1'b0;
         ce  = (cyc % div == 0);
         cycle();
      end
   endtask

   initial begin
      int p, d, div;
      rst = 1'b1;
      ce  = 1'b0;
      pwm = 1'b1;
      repeat (3) cycle();
      check_eq("rst_period", 32'(period), 32'd0);
      check_eq("rst_valid", 32'(valid), 32'd0);
      rst = 1'b0;

      drive(1'b1, 8);
      check_eq("high_at_release_nolock", 32'(locked), 32'd0);

      run_pwm(10, 3, 1, 6);
      flush(1);
      check_eq("loop_period", 32'(period), 32'd10);
      check_eq("loop_duty", 32'(duty), 32'd3);

      run_pwm(10, 7, 1, 4);
      flush(1);
      check_eq("dchg_period", 32'(period), 32'd10);
      check_eq("dchg_duty", 32'(duty), 32'd7);

      run_pwm(10, 3, 4, 4);
      flush(4);
      check_eq("presc_period", 32'(period), 32'd10);
      check_eq("presc_duty", 32'(duty), 32'd3);

      vcount = 0; ocount = 0;
      drive(1'b0, 300);
      check_eq("low_tail_ovf", 32'(ocount), 32'd1);
      check_eq("low_tail_novalid", 32'(vcount), 32'd0);

      vcount = 0; ocount = 0;
      drive(1'b1, 300);
      check_eq("const_high_ovf", 32'(ocount), 32'd1);
      check_eq("const_high_novalid", 32'(vcount), 32'd0);
      check_eq("const_high_unlocked", 32'(locked), 32'd0);
      check_eq("const_high_keep_period", 32'(period), 32'd10);
      check_eq("const_high_keep_duty", 32'(duty), 32'd3);

      rst = 1'b1;
      pwm = 1'b0;
      cycle();
      rst = 1'b0;
      vcount = 0; ocount = 0;
      drive(1'b0, 300);
      check_eq("const_low_novalid", 32'(vcount), 32'd0);
      check_eq("const_low_noovf", 32'(ocount), 32'd0);

      vcount = 0; ocount = 0;
      run_pwm(255, 100, 1, 3);
      check_eq("p255_valids", 32'(vcount), 32'd2);
      check_eq("p255_noovf", 32'(ocount), 32'd0);
      check_eq("p255_period", 32'(period), 32'd255);
      check_eq("p255_duty", 32'(duty), 32'd100);

      ocount = 0;
      run_pwm(256, 100, 1, 3);
      check_eq("p256_ovf", 32'(ocount >= 2), 32'd1);
      run_pwm(20, 5, 1, 3);
      flush(1);
      check_eq("relock_period", 32'(period), 32'd20);
      check_eq("relock_duty", 32'(duty), 32'd5);

      for (int k = 0; k < 6; k++) begin
         p   = int'($urandom_range(60, 2));
         d   = int'($urandom_range(p - 1, 1));
         div = int'($urandom_range(3, 1));
         run_pwm(p, d, div, 3);
         flush(div);
         check_eq("rand_cfg_period", 32'(period), 32'(p));
         check_eq("rand_cfg_duty", 32'(duty), 32'(d));
      end

      // Reset while high.
      run_pwm(10, 3, 1, 3);
      drive(1'b1, 4);
      check_eq("pre_rst_high_locked", 32'(locked), 32'd1);
      rst = 1'b1;
      cycle();
      check_eq("rst_high_period", 32'(period), 32'd0);
      check_eq("rst_high_locked", 32'(locked), 32'd0);
      rst = 1'b0;
      vcount = 0;
      drive(1'b1, 20);
      check_eq("rel_high_novalid", 32'(vcount), 32'd0);
      check_eq("rel_high_nolock", 32'(locked), 32'd0);
      drive(1'b0, 5);
      drive(1'b1, 4);
      drive(1'b0, 6);
      drive(1'b1, 4);
      check_eq("rel_seq_valids", 32'(vcount), 32'd1);
      check_eq("rel_seq_period", 32'(period), 32'd10);
      check_eq("rel_seq_duty", 32'(duty), 32'd4);

      // Reset while low.
      drive(1'b0, 3);
      rst = 1'b1;
      cycle();
      check_eq("rst_low_duty", 32'(duty), 32'd0);
      check_eq("rst_low_locked", 32'(locked), 32'd0);
      rst = 1'b0;

      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(99, 0) < 6) pwm = ~pwm;
         ce  = ($urandom_range(3, 0) != 0);
         rst = ($urandom_range(799, 0) == 0);
         cycle();
      end
      rst = 1'b0;
      cycle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
